pdu_reader: RTL and testbench
=============================

Name: pdu_reader

Overview:
- Read-side counterpart of the PCIe packet/descriptor buffer pair filled by the RX PDU generator.
- Pops one pkt_desc_t from the descriptor FIFO, then pops exactly `size` flit_lite_t flits from the packet FIFO.
- Emits the flits on a valid/ready stream tagged with dsc_queue_id/pkt_queue_id, for the PCIe DMA write engine.
- Cross-checks sop/eop framing against the descriptor size and resynchronises on mismatch.

Parameters:
- MAX_FLITS, 16'd64: sanity limit on descriptor size in flits; larger sizes are errors.
- ERR_CNT_W, 16: width of the framing-error counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pcie_desc_buf_rd_data  in  pkt_desc_t  head of descriptor FIFO (show-ahead)
- pcie_desc_buf_rd_valid  in  1  descriptor FIFO non-empty
- pcie_desc_buf_rd_en  out  1  pop descriptor (combinational)
- pcie_pkt_buf_rd_data  in  flit_lite_t  head of packet FIFO (show-ahead)
- pcie_pkt_buf_rd_valid  in  1  packet FIFO non-empty
- pcie_pkt_buf_rd_en  out  1  pop flit (combinational)
- out_data  out  512  flit payload, passed through unmodified
- out_sop  out  1  first flit of packet
- out_eop  out  1  last flit of packet
- out_err  out  1  framing error, qualifies an eop flit
- out_dsc_queue_id  out  APP_IDX_WIDTH  from descriptor, held for whole packet
- out_pkt_queue_id  out  FLOW_IDX_WIDTH  from descriptor, held for whole packet
- out_size  out  16  descriptor flit count, held for whole packet
- out_valid  out  1  output flit valid
- out_ready  in  1  downstream accept
- err_cnt  out  ERR_CNT_W  saturating framing-error count

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; remaining=0.
- Reset mid-packet: the packet is abandoned and FIFOs are not popped during reset. Flushing is the owner's job.
- Output register: out_* is a single register stage.
- Load condition: can_load = !out_valid || out_ready.
- out_valid drop: clears when out_ready && !load.
- Stable data: out_* data is held while out_valid && !out_ready.
- Latency: one cycle from flit pop to out_valid.
- State IDLE:
  - If pcie_desc_buf_rd_valid, assert pcie_desc_buf_rd_en for exactly one cycle.
  - Latch the queue ids and size; set remaining=size, first=1.
  - If size==0 or size>MAX_FLITS: err_cnt++ and stay IDLE; the descriptor is consumed and no flits are popped.
  - Otherwise go to STREAM.
- State STREAM:
  - Pop: pcie_pkt_buf_rd_en = pcie_pkt_buf_rd_valid && can_load. On pop, load the flit into the output register.
  - On pop, out_sop = first, out_eop = (remaining==1) and remaining decrements.
  - Error when any of: first && !sop; !first && sop; remaining==1 && !eop; remaining>1 && eop.
  - On error: the flit is still emitted with out_eop=1 and out_err=1, and err_cnt++.
  - After an error flit: go to DROP if the flit's eop=0, else to IDLE.
  - Good last flit: go to IDLE.
  - A new descriptor pop may occur the cycle after the last flit pop, giving a one-cycle bubble between packets.
- State DROP:
  - Pop flits whenever pcie_pkt_buf_rd_valid, independent of out_ready; nothing is emitted.
  - Leave to IDLE after popping a flit with eop=1.
- Descriptor pop: never in STREAM or DROP.
- Flit pop: never in IDLE.
- err_cnt saturates at all-ones.
- Empty FIFO mid-packet: stall with no pop and no error; out_valid falls once the held flit is accepted.

Optional Feature:
- Macro: PDU_READER_STATS_EN.
- Defined: adds outputs pkt_cnt[31:0] and flit_cnt[31:0], both wrapping.
  - pkt_cnt increments when an out_eop flit with out_err=0 is accepted (out_valid && out_ready).
  - flit_cnt increments on every accepted flit.
  - Both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Descriptor {dsc=3, pkt=7, size=3} with 3 flits (sop,-,eop), out_ready=1:
  - out_valid for 3 consecutive cycles starting one cycle after the first flit pop; sop on flit 1, eop on flit 3.
  - Queue ids 3/7 and out_size=3 on every flit; err_cnt=0.
- Same packet with out_ready toggling 1,0,0,1,...:
  - out_data/out_sop/out_eop stable while stalled; no extra pops; exactly 3 flits delivered.
- Two back-to-back size-1 descriptors with sop=eop=1 flits:
  - Two single-flit outputs, each sop=eop=1; second desc pop exactly one cycle after first flit pop.
- Descriptor size=4 with flits sop,-,eop followed by next packet sop,eop and size=2 descriptor:
  - Third flit emitted with out_eop=1, out_err=1 and err_cnt=1.
  - Next packet delivered intact.
- Descriptor size=2 with flits sop,-,-,eop:
  - Second flit emitted with out_err=1; flits 3-4 dropped; err_cnt=1; state returns to IDLE.
- Descriptor size=0, then rst asserted mid-STREAM:
  - err_cnt=1 with no flit popped.
  - After rst: all outputs 0 and err_cnt=0.

Source files
------------

// File: rtl/pdu_reader.sv
// pdu_reader: drains the PCIe descriptor/packet FIFO pair filled by the RX PDU
// generator. Pops one descriptor, then exactly `size` flits, and emits them on
// a valid/ready stream tagged with the descriptor's queue ids. Framing (sop/eop)
// is checked against the descriptor size; on mismatch the offending flit is
// closed out with out_eop=out_err=1 and the rest of the packet is discarded.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pcie_desc_buf_rd_*         show-ahead descriptor FIFO read side
//   pcie_pkt_buf_rd_*          show-ahead packet (flit) FIFO read side
//   out_data/sop/eop/err       registered output flit and framing flags
//   out_dsc_queue_id,
//   out_pkt_queue_id, out_size descriptor fields, held for the whole packet
//   out_valid/out_ready        output handshake
//   err_cnt                    saturating framing-error count
//   pkt_cnt, flit_cnt          only with PDU_READER_STATS_EN defined:
//                              wrapping counts of accepted good packets/flits

package pdu_reader_pkg;
  localparam int APP_IDX_WIDTH  = 5;
  localparam int FLOW_IDX_WIDTH = 9;

  typedef struct packed {
    logic [APP_IDX_WIDTH-1:0]  dsc_queue_id;
    logic [FLOW_IDX_WIDTH-1:0] pkt_queue_id;
    logic [15:0]               size;
  } pkt_desc_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
  } flit_lite_t;
endpackage

module pdu_reader
  import pdu_reader_pkg::*;
#(
  parameter logic [15:0] MAX_FLITS = 16'd64,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  pkt_desc_t                 pcie_desc_buf_rd_data,
  input  logic                      pcie_desc_buf_rd_valid,
  output logic                      pcie_desc_buf_rd_en,
  input  flit_lite_t                pcie_pkt_buf_rd_data,
  input  logic                      pcie_pkt_buf_rd_valid,
  output logic                      pcie_pkt_buf_rd_en,
  output logic [511:0]              out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic                      out_err,
  output logic [APP_IDX_WIDTH-1:0]  out_dsc_queue_id,
  output logic [FLOW_IDX_WIDTH-1:0] out_pkt_queue_id,
  output logic [15:0]               out_size,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef PDU_READER_STATS_EN
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               flit_cnt,
`endif
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DROP
  } state_t;

  state_t                    state, state_nxt;
  logic [15:0]               remaining, remaining_nxt;
  logic                      first, first_nxt;

  // Descriptor fields are staged here rather than in out_* so a flit still
  // held by backpressure keeps its own tags while the next descriptor loads.
  logic [APP_IDX_WIDTH-1:0]  cur_dsc;
  logic [FLOW_IDX_WIDTH-1:0] cur_pkt;
  logic [15:0]               cur_size;

  logic can_load;
  logic desc_take;
  logic load;
  logic flit_err;
  logic err_inc;

  assign can_load = !out_valid || out_ready;

  always_comb begin
    state_nxt           = state;
    remaining_nxt       = remaining;
    first_nxt           = first;
    pcie_desc_buf_rd_en = 1'b0;
    pcie_pkt_buf_rd_en  = 1'b0;
    desc_take           = 1'b0;
    load                = 1'b0;
    flit_err            = 1'b0;
    err_inc             = 1'b0;

    case (state)
      IDLE: begin
        if (pcie_desc_buf_rd_valid) begin
          pcie_desc_buf_rd_en = 1'b1;
          desc_take           = 1'b1;
          remaining_nxt       = pcie_desc_buf_rd_data.size;
          first_nxt           = 1'b1;
          if (pcie_desc_buf_rd_data.size == 16'd0 ||
              pcie_desc_buf_rd_data.size > MAX_FLITS) begin
            err_inc = 1'b1;
          end else begin
            state_nxt = STREAM;
          end
        end
      end

      STREAM: begin
        if (pcie_pkt_buf_rd_valid && can_load) begin
          pcie_pkt_buf_rd_en = 1'b1;
          load               = 1'b1;
          flit_err = (first && !pcie_pkt_buf_rd_data.sop) ||
                     (!first && pcie_pkt_buf_rd_data.sop) ||
                     (remaining == 16'd1 && !pcie_pkt_buf_rd_data.eop) ||
                     (remaining > 16'd1 && pcie_pkt_buf_rd_data.eop);
          remaining_nxt = remaining - 16'd1;
          first_nxt     = 1'b0;
          if (flit_err) begin
            err_inc   = 1'b1;
            // An erroring flit that already carries eop ends the packet;
            // otherwise the remainder up to the next eop must be discarded.
            state_nxt = pcie_pkt_buf_rd_data.eop ? IDLE : DROP;
          end else if (remaining == 16'd1) begin
            state_nxt = IDLE;
          end
        end
      end

      DROP: begin
        if (pcie_pkt_buf_rd_valid) begin
          pcie_pkt_buf_rd_en = 1'b1;
          if (pcie_pkt_buf_rd_data.eop) begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // No FIFO pops while reset is held.
    if (rst) begin
      pcie_desc_buf_rd_en = 1'b0;
      pcie_pkt_buf_rd_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      remaining        <= '0;
      first            <= 1'b0;
      cur_dsc          <= '0;
      cur_pkt          <= '0;
      cur_size         <= '0;
      out_data         <= '0;
      out_sop          <= 1'b0;
      out_eop          <= 1'b0;
      out_err          <= 1'b0;
      out_dsc_queue_id <= '0;
      out_pkt_queue_id <= '0;
      out_size         <= '0;
      out_valid        <= 1'b0;
      err_cnt          <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      first     <= first_nxt;

      if (desc_take) begin
        cur_dsc  <= pcie_desc_buf_rd_data.dsc_queue_id;
        cur_pkt  <= pcie_desc_buf_rd_data.pkt_queue_id;
        cur_size <= pcie_desc_buf_rd_data.size;
      end

      if (load) begin
        out_data         <= pcie_pkt_buf_rd_data.data;
        out_sop          <= first;
        out_eop          <= (remaining == 16'd1) || flit_err;
        out_err          <= flit_err;
        out_dsc_queue_id <= cur_dsc;
        out_pkt_queue_id <= cur_pkt;
        out_size         <= cur_size;
        out_valid        <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (err_inc && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

`ifdef PDU_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else if (out_valid && out_ready) begin
      flit_cnt <= flit_cnt + 32'd1;
      if (out_eop && !out_err) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdu_reader.sv
module tb_pdu_reader;
  import pdu_reader_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  pkt_desc_t                 desc_data;
  logic                      desc_valid;
  logic                      desc_rd_en;
  flit_lite_t                pkt_data;
  logic                      pkt_valid;
  logic                      pkt_rd_en;
  logic [511:0]              out_data;
  logic                      out_sop, out_eop, out_err, out_valid;
  logic                      out_ready = 1'b1;
  logic [APP_IDX_WIDTH-1:0]  out_dsc_queue_id;
  logic [FLOW_IDX_WIDTH-1:0] out_pkt_queue_id;
  logic [15:0]               out_size;
  logic [15:0]               err_cnt;
`ifdef PDU_READER_STATS_EN
  logic [31:0]               pkt_cnt, flit_cnt;
`endif

  pdu_reader #(.MAX_FLITS(16'd64), .ERR_CNT_W(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .pcie_desc_buf_rd_data  (desc_data),
    .pcie_desc_buf_rd_valid (desc_valid),
    .pcie_desc_buf_rd_en    (desc_rd_en),
    .pcie_pkt_buf_rd_data   (pkt_data),
    .pcie_pkt_buf_rd_valid  (pkt_valid),
    .pcie_pkt_buf_rd_en     (pkt_rd_en),
    .out_data               (out_data),
    .out_sop                (out_sop),
    .out_eop                (out_eop),
    .out_err                (out_err),
    .out_dsc_queue_id       (out_dsc_queue_id),
    .out_pkt_queue_id       (out_pkt_queue_id),
    .out_size               (out_size),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
`ifdef PDU_READER_STATS_EN
    .pkt_cnt                (pkt_cnt),
    .flit_cnt               (flit_cnt),
`endif
    .err_cnt                (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0]              data;
    logic                      sop;
    logic                      eop;
    logic                      err;
    logic [APP_IDX_WIDTH-1:0]  dsc;
    logic [FLOW_IDX_WIDTH-1:0] pkt;
    logic [15:0]               size;
  } oflit_t;

  int total = 0;
  int bad   = 0;

  pkt_desc_t  desc_q[$], desc_hist[$];
  flit_lite_t flit_q[$], flit_hist[$];
  oflit_t     obs_q[$], exp_q[$];
  int         exp_err;
  int         pop_cyc[$], val_cyc[$], dpop_cyc[$];
  int         cyc = 0;
  int         ready_mode = 0;
  int         rpat = 0;
  int         stall_bad = 0;
  bit         prev_stall = 0;
  logic [514:0] prev_out;

  task automatic refresh();
    desc_valid = (desc_q.size() > 0);
    desc_data  = desc_valid ? desc_q[0] : '0;
    pkt_valid  = (flit_q.size() > 0);
    pkt_data   = pkt_valid ? flit_q[0] : '0;
  endtask

  // Show-ahead FIFO models and out_ready pattern, all updated just after the edge.
  always @(posedge clk) begin
    bit dpop, ppop;
    dpop = desc_rd_en;
    ppop = pkt_rd_en;
    cyc++;
    #1;
    if (dpop && desc_q.size() > 0) desc_q.delete(0);
    if (ppop && flit_q.size() > 0) flit_q.delete(0);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = (rpat % 3) == 0; rpat++; end
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    refresh();
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      oflit_t o;
      if (pkt_rd_en)  pop_cyc.push_back(cyc);
      if (desc_rd_en) dpop_cyc.push_back(cyc);
      if (out_valid)  val_cyc.push_back(cyc);
      if (prev_stall && ({out_data, out_sop, out_eop, out_err} !== prev_out)) stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_data, out_sop, out_eop, out_err};
      if (out_valid && out_ready) begin
        o.data = out_data; o.sop = out_sop; o.eop = out_eop; o.err = out_err;
        o.dsc = out_dsc_queue_id; o.pkt = out_pkt_queue_id; o.size = out_size;
        obs_q.push_back(o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    desc_q.delete(); flit_q.delete(); desc_hist.delete(); flit_hist.delete();
    obs_q.delete(); pop_cyc.delete(); val_cyc.delete(); dpop_cyc.delete();
    stall_bad = 0; rpat = 0;
    refresh();
    wait_cyc(3);
    rst = 1'b0;
  endtask

  task automatic push_desc(input int dsc, input int pkt, input int size);
    pkt_desc_t d;
    d.dsc_queue_id = dsc[APP_IDX_WIDTH-1:0];
    d.pkt_queue_id = pkt[FLOW_IDX_WIDTH-1:0];
    d.size         = size[15:0];
    desc_q.push_back(d);
    desc_hist.push_back(d);
    refresh();
  endtask

  task automatic push_flit(input bit sop, input bit eop);
    flit_lite_t f;
    for (int i = 0; i < 16; i++) f.data[i*32 +: 32] = $urandom();
    f.sop = sop;
    f.eop = eop;
    flit_q.push_back(f);
    flit_hist.push_back(f);
    refresh();
  endtask

  // Packet-level reference: walk descriptors, consume `size` flits each, tag
  // any flit whose sop/eop disagree with its position, discard to next eop.
  task automatic build_expected();
    int fi;
    fi = 0;
    exp_err = 0;
    exp_q.delete();
    foreach (desc_hist[di]) begin
      pkt_desc_t d;
      d = desc_hist[di];
      if (d.size == 0 || d.size > 64) begin
        exp_err++;
        continue;
      end
      for (int k = 0; k < int'(d.size) && fi < flit_hist.size(); k++) begin
        flit_lite_t f;
        oflit_t     o;
        bit         is_first, is_last, e;
        f = flit_hist[fi];
        fi++;
        is_first = (k == 0);
        is_last  = (k == int'(d.size) - 1);
        e = (f.sop != is_first) || (f.eop != is_last);
        o.data = f.data; o.sop = is_first; o.eop = is_last || e; o.err = e;
        o.dsc = d.dsc_queue_id; o.pkt = d.pkt_queue_id; o.size = d.size;
        exp_q.push_back(o);
        if (e) begin
          exp_err++;
          if (!f.eop) begin
            while (fi < flit_hist.size() && !flit_hist[fi].eop) fi++;
            fi++;
          end
          break;
        end
      end
    end
  endtask

  task automatic check_run(input string name);
    int budget;
    budget = 3000;
    while (budget > 0 && !(desc_q.size() == 0 && flit_q.size() == 0 && !out_valid)) begin
      wait_cyc(1);
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL %s_drain: got=timeout required=drained", name);
    end
    wait_cyc(3);
    build_expected();
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got=%0d required=%0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_flit[%0d]: got=%h required=%h", name, i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (err_cnt !== exp_err[15:0]) begin
      bad++;
      $display("FAIL %s_err_cnt: got=%0d required=%0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if ({out_valid, out_sop, out_eop, out_err, out_dsc_queue_id, out_pkt_queue_id,
         out_size, err_cnt, desc_rd_en, pkt_rd_en} !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got=%b required=0", {out_valid, out_sop, out_eop, out_err, err_cnt});
    end
    wait_cyc(1);
  endtask

  task automatic test_basic();
    apply_reset();
    ready_mode = 0;
    push_desc(3, 7, 3);
    push_flit(1, 0); push_flit(0, 0); push_flit(0, 1);
    check_run("basic");
    total++;
    if (pop_cyc.size() != 3 || val_cyc.size() != 3) begin
      bad++;
      $display("FAIL basic_pops: got=%0d/%0d required=3/3", pop_cyc.size(), val_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (val_cyc[i] != pop_cyc[0] + 1 + i) begin
          bad++;
          $display("FAIL basic_valid_cycle[%0d]: got=%0d required=%0d", i, val_cyc[i], pop_cyc[0] + 1 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready_mode = 1;
    push_desc(3, 7, 3);
    push_flit(1, 0); push_flit(0, 0); push_flit(0, 1);
    check_run("bp");
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL bp_stable: got=%0d changes required=0", stall_bad);
    end
    total++;
    if (pop_cyc.size() != 3) begin
      bad++;
      $display("FAIL bp_pops: got=%0d required=3", pop_cyc.size());
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_desc(1, 2, 1); push_desc(4, 5, 1);
    push_flit(1, 1); push_flit(1, 1);
    check_run("b2b");
    total++;
    if (dpop_cyc.size() != 2 || pop_cyc.size() != 2) begin
      bad++;
      $display("FAIL b2b_pops: got=%0d/%0d required=2/2", dpop_cyc.size(), pop_cyc.size());
    end else if (dpop_cyc[1] != pop_cyc[0] + 1) begin
      bad++;
      $display("FAIL b2b_desc_gap: got=%0d required=%0d", dpop_cyc[1], pop_cyc[0] + 1);
    end
  endtask

  task automatic test_long_desc();
    apply_reset();
    push_desc(2, 9, 4);
    push_flit(1, 0); push_flit(0, 0); push_flit(0, 1);
    push_desc(6, 1, 2);
    push_flit(1, 0); push_flit(0, 1);
    check_run("long");
    total++;
    if (obs_q.size() != 5 || obs_q[2].eop !== 1'b1 || obs_q[2].err !== 1'b1 || err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL long_err_flit: got=n%0d err_cnt=%0d required=n5 eop=1 err=1 err_cnt=1", obs_q.size(), err_cnt);
    end
  endtask

  task automatic test_short_desc();
    apply_reset();
    push_desc(5, 4, 2);
    push_flit(1, 0); push_flit(0, 0); push_flit(0, 0); push_flit(0, 1);
    push_desc(7, 8, 1);
    push_flit(1, 1);
    check_run("short");
    total++;
    if (obs_q.size() != 3 || obs_q[1].err !== 1'b1 || obs_q[2].err !== 1'b0 || err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL short_drop: got=n%0d err_cnt=%0d required=n3 err_cnt=1", obs_q.size(), err_cnt);
    end
  endtask

  task automatic test_bad_size_reset();
    apply_reset();
    push_desc(1, 1, 0);
    wait_cyc(5);
    total++;
    if (err_cnt !== 16'd1 || pop_cyc.size() != 0 || desc_q.size() != 0) begin
      bad++;
      $display("FAIL zero_size: got=err_cnt %0d pops %0d required=err_cnt 1 pops 0", err_cnt, pop_cyc.size());
    end
    push_desc(2, 3, 4);
    push_flit(1, 0); push_flit(0, 0);
    wait_cyc(10);
    total++;
    if (pop_cyc.size() != 2 || out_valid !== 1'b0 || err_cnt !== 16'd1) begin
      bad++;
      $display("FAIL empty_stall: got=pops %0d valid %b err %0d required=pops 2 valid 0 err 1",
               pop_cyc.size(), out_valid, err_cnt);
    end
    rst = 1'b1;
    push_desc(3, 3, 1);
    push_flit(0, 1);
    @(negedge clk);
    total++;
    if (desc_rd_en !== 1'b0 || pkt_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_pop: got=%b%b required=00", desc_rd_en, pkt_rd_en);
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_sop, out_eop, out_err, out_dsc_queue_id, out_pkt_queue_id,
         out_size, err_cnt} !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_mid_stream: got=valid %b err_cnt %0d required=0", out_valid, err_cnt);
    end
    apply_reset();
  endtask

  task automatic test_random(input int mode, input string name);
    apply_reset();
    ready_mode = mode;
    for (int p = 0; p < 40; p++) begin
      int len, kind, size;
      len  = $urandom_range(1, 6);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        size = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 200);
        push_desc($urandom, $urandom, size);
      end else begin
        if (kind == 1)      size = len + $urandom_range(1, 3);
        else if (kind == 2) size = (len > 1) ? $urandom_range(1, len - 1) : len + 1;
        else                size = len;
        push_desc($urandom, $urandom, size);
        for (int k = 0; k < len; k++) push_flit(k == 0, k == len - 1);
      end
    end
    check_run(name);
    ready_mode = 0;
  endtask

  initial begin
    refresh();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_long_desc();
    test_short_desc();
    test_bad_size_reset();
    test_random(2, "rand_rdy");
    test_random(0, "rand_full");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
